// File: rtl/event_scheduler.sv
`default_nettype none
// ============================================================================
// Module : event_scheduler
// Timestamps input events and periodic deadlines, queues them in a small FIFO
// and issues them one at a time to the evaluator (valid/ready/done).
// Rev    : 1.0
// ============================================================================
module event_scheduler #(
  parameter int         DATA_W        = 64,
  parameter int         TS_W          = 64,
  parameter int         PERIOD_CYCLES = 500,
  parameter int         QUEUE_DEPTH   = 4,
  parameter logic [3:0] PERIODIC_MASK = 4'b1110
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] input_0,
  input  logic                     new_input_0,
  output logic                     eval_valid,
  input  logic                     eval_ready,
  input  logic                     eval_done,
  output logic signed [DATA_W-1:0] eval_data,
  output logic [TS_W-1:0]          eval_ts,
  output logic                     enable_in0,
  output logic                     enable_out0,
  output logic                     enable_out1,
  output logic                     enable_out2,
  output logic                     enable_out3,
  output logic                     q_push,
  output logic                     q_push_valid,
  output logic                     q_pop,
  output logic                     q_pop_valid,
  output logic                     overflow
);

  localparam int c_per_w = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int c_ptr_w = (QUEUE_DEPTH > 2) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(QUEUE_DEPTH + 1);
  localparam logic [c_per_w-1:0] c_period_last = c_per_w'(PERIOD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_full        = c_cnt_w'(QUEUE_DEPTH);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic              in_flag;
    logic              dl_flag;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  logic [TS_W-1:0]    ts_q, ts_d;
  logic [c_per_w-1:0] period_q, period_d;
  entry_t             mem_q [QUEUE_DEPTH];
  entry_t             mem_d [QUEUE_DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  state_t             state_q, state_d;
  entry_t             lat_q, lat_d;
  logic               overflow_q, overflow_d;

  logic   w_deadline;
  logic   w_event;
  logic   w_full;
  logic   w_empty;
  logic   w_pop;
  logic   w_accept;
  logic   w_active;
  entry_t w_new_entry;
  entry_t w_cur;
  logic [3:0] w_out_en;

  always_comb begin
    w_deadline          = (period_q == c_period_last);
    w_event             = en & ~rst & (new_input_0 | w_deadline);
    w_full              = (count_q == c_full);
    w_empty             = (count_q == '0);
    w_pop               = en & ~rst & (state_q == ISSUE) & eval_ready;
    // A full FIFO still takes the new event when the head leaves this cycle.
    w_accept            = w_event & (~w_full | w_pop);
    w_new_entry.ts      = ts_q;
    w_new_entry.in_flag = new_input_0;
    w_new_entry.dl_flag = w_deadline;
    w_new_entry.data    = new_input_0 ? input_0 : '0;
  end

  always_comb begin
    ts_d       = ts_q;
    period_d   = period_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    lat_d      = lat_q;
    overflow_d = overflow_q;

    if (en) begin
      ts_d     = ts_q + TS_W'(1);
      period_d = w_deadline ? '0 : period_q + c_per_w'(1);

      if (w_accept) begin
        mem_d[wr_ptr_q] = w_new_entry;
        wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   count_d = count_q + c_cnt_w'(1);
        2'b01:   count_d = count_q - c_cnt_w'(1);
        default: count_d = count_q;
      endcase
      if (w_event && !w_accept) begin
        overflow_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (!w_empty) state_d = ISSUE;
        end
        ISSUE: begin
          if (w_pop) begin
            lat_d   = mem_q[rd_ptr_q];
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (eval_done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      period_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      lat_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ts_q       <= ts_d;
      period_q   <= period_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      lat_q      <= lat_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  // ISSUE shows the live FIFO head; BUSY shows the copy taken at the pop.
  always_comb begin
    w_active = (state_q == ISSUE) || (state_q == BUSY);
    w_cur    = (state_q == BUSY) ? lat_q : mem_q[rd_ptr_q];
    for (int i = 0; i < 4; i++) begin
      w_out_en[i] = w_active & (PERIODIC_MASK[i] ? w_cur.dl_flag : w_cur.in_flag);
    end
  end

  assign eval_valid   = (state_q == ISSUE);
  assign eval_data    = w_active ? w_cur.data : '0;
  assign eval_ts      = w_active ? w_cur.ts : '0;
  assign enable_in0   = w_active & w_cur.in_flag;
  assign enable_out0  = w_out_en[0];
  assign enable_out1  = w_out_en[1];
  assign enable_out2  = w_out_en[2];
  assign enable_out3  = w_out_en[3];
  assign q_push       = w_event;
  assign q_push_valid = w_accept;
  assign q_pop        = w_pop;
  assign q_pop_valid  = ~w_empty;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_event_scheduler.sv
`default_nettype none
// Directed bench for event_scheduler: expected issues are queued when events
// are created and compared when the evaluator handshake completes.
module tb_event_scheduler;

  logic               clk = 1'b0;
  logic               rst, en, new_input_0, eval_ready, eval_done;
  logic signed [63:0] input_0;
  logic               eval_valid, enable_in0;
  logic               enable_out0, enable_out1, enable_out2, enable_out3;
  logic               q_push, q_push_valid, q_pop, q_pop_valid, overflow;
  logic signed [63:0] eval_data;
  logic [63:0]        eval_ts;

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] ts;
    logic [4:0]  ens;   // {out3, out2, out1, out0, in0}
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] tb_ts;
  logic [63:0] first_ts;

  event_scheduler #(
    .DATA_W(64), .TS_W(64), .PERIOD_CYCLES(500), .QUEUE_DEPTH(4), .PERIODIC_MASK(4'b1110)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .input_0(input_0), .new_input_0(new_input_0),
    .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_done(eval_done),
    .eval_data(eval_data), .eval_ts(eval_ts), .enable_in0(enable_in0),
    .enable_out0(enable_out0), .enable_out1(enable_out1), .enable_out2(enable_out2),
    .enable_out3(enable_out3), .q_push(q_push), .q_push_valid(q_push_valid),
    .q_pop(q_pop), .q_pop_valid(q_pop_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_ts <= '0;
    else if (en) tb_ts <= tb_ts + 64'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ens_now();
    return {enable_out3, enable_out2, enable_out1, enable_out0, enable_in0};
  endfunction

  // Outputs 1..3 are deadline-driven, output 0 and in0 follow the input strobe.
  task automatic push_exp(input logic [63:0] d, input logic [63:0] ts, input logic in_f, input logic dl_f);
    exp_t e;
    e.data = d;
    e.ts   = ts;
    e.ens  = {dl_f, dl_f, dl_f, in_f, in_f};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && eval_valid && eval_ready) begin
      check1("handshake_q_pop", q_pop, 1'b1);
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_issue: observed data 0x%0h ts %0d expected no issue", eval_data, eval_ts);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("issue_data", eval_data, mon_e.data);
        check("issue_ts", eval_ts, mon_e.ts);
        check("issue_enables", 64'(ens_now()), 64'(mon_e.ens));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ts(input logic [63:0] target);
    int k = 0;
    while (tb_ts != target && k < 2000) begin
      cyc();
      k++;
    end
    if (tb_ts != target) begin
      n_cmp++;
      n_fail++;
      $error("FAIL wait_ts: observed ts %0d expected %0d", tb_ts, target);
    end
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      cyc();
      k++;
    end
    cyc();
    cyc();
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    cyc();
    check1({tag, "_eval_valid"}, eval_valid, 1'b0);
    check({tag, "_enables"}, 64'(ens_now()), 64'd0);
    check({tag, "_eval_data"}, eval_data, 64'd0);
    check({tag, "_eval_ts"}, eval_ts, 64'd0);
    check1({tag, "_q_pop_valid"}, q_pop_valid, 1'b0);
    check1({tag, "_overflow"}, overflow, 1'b0);
    check1({tag, "_q_push"}, q_push, 1'b0);
    check1({tag, "_q_pop"}, q_pop, 1'b0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; new_input_0 = 1'b0; input_0 = '0;
    eval_ready = 1'b0; eval_done = 1'b0;
    do_reset("rst0");

    // Deadlines every 500 cycles, plus one input event in between.
    eval_ready = 1'b1;
    eval_done  = 1'b1;
    wait_ts(64'd499);
    check1("t1_push_dl499", q_push, 1'b1);
    push_exp(64'd0, 64'd499, 1'b0, 1'b1);
    wait_ts(64'd600);
    new_input_0 = 1'b1; input_0 = 64'sd9; #1;
    check1("t2_push", q_push, 1'b1);
    check1("t2_push_valid", q_push_valid, 1'b1);
    push_exp(64'd9, 64'd600, 1'b1, 1'b0);
    cyc();
    new_input_0 = 1'b0;
    check1("t2_valid_at_t1", eval_valid, 1'b0);
    cyc();
    check1("t2_valid_at_t2", eval_valid, 1'b1);
    check("t2_data_at_t2", eval_data, 64'd9);
    wait_drain(20);

    // en=0 freezes everything and masks the strobe.
    en = 1'b0; new_input_0 = 1'b1; input_0 = 64'sd77; #1;
    check1("en0_q_push", q_push, 1'b0);
    cyc();
    cyc();
    check1("en0_q_pop_valid", q_pop_valid, 1'b0);
    new_input_0 = 1'b0; en = 1'b1;
    wait_ts(64'd999);
    check1("t1_push_dl999", q_push, 1'b1);
    push_exp(64'd0, 64'd999, 1'b0, 1'b1);
    wait_drain(20);

    // Input strobe coinciding with the deadline merges into one event.
    do_reset("rst1");
    wait_ts(64'd499);
    new_input_0 = 1'b1; input_0 = -64'sd3; #1;
    check1("t3_push", q_push, 1'b1);
    push_exp(64'hFFFF_FFFF_FFFF_FFFD, 64'd499, 1'b1, 1'b1);
    cyc();
    new_input_0 = 1'b0;
    wait_drain(20);
    check1("t3_single_event", q_pop_valid, 1'b0);

    // Five events into a depth-4 FIFO with the evaluator stalled.
    wait_ts(64'd520);
    eval_ready = 1'b0;
    first_ts = tb_ts;
    for (int i = 1; i <= 5; i++) begin
      new_input_0 = 1'b1; input_0 = 64'(i); #1;
      check1($sformatf("t4_push_valid_%0d", i), q_push_valid, (i <= 4));
      if (i <= 4) push_exp(64'(i), tb_ts, 1'b1, 1'b0);
      cyc();
    end
    new_input_0 = 1'b0;
    check1("t4_overflow", overflow, 1'b1);
    check1("t4_q_pop_valid", q_pop_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check1("t4_stall_valid", eval_valid, 1'b1);
      check("t4_stall_data", eval_data, 64'd1);
      check("t4_stall_ts", eval_ts, first_ts);
      cyc();
    end
    eval_ready = 1'b1;
    wait_drain(40);

    // Evaluator holds done low for 10 cycles while a second event waits.
    eval_done = 1'b0;
    new_input_0 = 1'b1; input_0 = 64'sd20; #1;
    push_exp(64'd20, tb_ts, 1'b1, 1'b0);
    cyc();
    input_0 = 64'sd21; #1;
    push_exp(64'd21, tb_ts, 1'b1, 1'b0);
    cyc();
    new_input_0 = 1'b0;
    check1("t5_issue_valid", eval_valid, 1'b1);
    cyc();
    for (int i = 0; i < 10; i++) begin
      check1("t5_busy_valid", eval_valid, 1'b0);
      check("t5_busy_data", eval_data, 64'd20);
      check1("t5_busy_in0", enable_in0, 1'b1);
      check1("t5_busy_out1", enable_out1, 1'b0);
      check1("t5_busy_q_pop_valid", q_pop_valid, 1'b1);
      cyc();
    end
    eval_done = 1'b1;
    wait_drain(20);

    // Reset while BUSY with two entries still queued.
    eval_done = 1'b0;
    new_input_0 = 1'b1; input_0 = 64'sd30; #1;
    push_exp(64'd30, tb_ts, 1'b1, 1'b0);
    cyc();
    input_0 = 64'sd31;
    cyc();
    input_0 = 64'sd32;
    cyc();
    new_input_0 = 1'b0;
    check1("t6_busy_valid", eval_valid, 1'b0);
    check1("t6_busy_in0", enable_in0, 1'b1);
    check1("t6_q_pop_valid", q_pop_valid, 1'b1);
    check1("t6_overflow_sticky", overflow, 1'b1);
    do_reset("rst2");
    eval_done = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    check1("t6_flushed", q_pop_valid, 1'b0);
    check1("t6_no_issue", eval_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
